// File: rtl/instr_sequencer.sv
// Fetch/decode/execute control sequencer for the 5-bit-address computer.
// Latency: NOP 3 cycles, JMP/JZ 4 cycles, LDA/ADD/SUB/STA 5 cycles; HLT parks until reset.
// Backpressure: none in the default build; with INSTR_SEQUENCER_SINGLE_STEP_EN,
//   T0 stalls until a step pulse is sampled.
//
// Ports:
//   clk, rst      system clock (posedge) and asynchronous active-high reset
//   step          (only with INSTR_SEQUENCER_SINGLE_STEP_EN) single-step request, sampled in T0
//   mem_data      RAM read data, valid in the cycle after mar_load
//   zero_flag     accumulator-zero flag, consulted by JZ in T3
//   mar_load      load MAR this cycle; mar_sel picks PC (0) or IR operand (1)
//   ir_load       internal IR capture strobe (debug export)
//   pc_inc        program_counter increment
//   jmp, jmp_add  program_counter jump request and target (always the IR operand)
//   acc_load      accumulator load; acc_src picks mem_data (0) or ALU result (1)
//   alu_sub       ALU op: 0 add, 1 subtract
//   mem_we        RAM write of accumulator to MAR address
//   halted        high while parked in HALT
//   state_dbg     current state encoding
//
// Optional feature macro: INSTR_SEQUENCER_SINGLE_STEP_EN

module instr_sequencer #(
  parameter int OPW = 3,
  parameter int ADW = 5
) (
  input  logic               clk,
  input  logic               rst,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic               step,
`endif
  input  logic [OPW+ADW-1:0] mem_data,
  input  logic               zero_flag,
  output logic               mar_load,
  output logic               mar_sel,
  output logic               ir_load,
  output logic               pc_inc,
  output logic               jmp,
  output logic [ADW-1:0]     jmp_add,
  output logic               acc_load,
  output logic               acc_src,
  output logic               alu_sub,
  output logic               mem_we,
  output logic               halted,
  output logic [2:0]         state_dbg
);

  // ---------------------------------------------------------------------------
  // Opcode map
  // ---------------------------------------------------------------------------
  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);
  localparam logic [OPW-1:0] OP_STA = OPW'(4);
  localparam logic [OPW-1:0] OP_JMP = OPW'(5);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(6);
  localparam logic [OPW-1:0] OP_HLT = OPW'(7);

  // ---------------------------------------------------------------------------
  // State encoding (visible on state_dbg, so the values are fixed)
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  state_t               state_q;
  state_t               state_nxt;
  logic [OPW+ADW-1:0]   ir_q;
  logic [OPW-1:0]       op;
  logic [ADW-1:0]       operand;
  logic                 is_mem_op;
  logic                 fetch_go;

  assign op      = ir_q[OPW+ADW-1:ADW];
  assign operand = ir_q[ADW-1:0];

  // LDA/ADD/SUB/STA all need a second memory access through the IR operand.
  assign is_mem_op = (op == OP_LDA) || (op == OP_ADD) ||
                     (op == OP_SUB) || (op == OP_STA);

  // ---------------------------------------------------------------------------
  // Single-step gate on the fetch cycle
  // ---------------------------------------------------------------------------
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  // step_arm_q latches a step pulse seen while waiting in T0; the following
  // T0 cycle then performs the real fetch. It clears once T0 is left, so the
  // next instruction waits for a fresh pulse.
  logic step_arm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_arm_q <= 1'b0;
    end else begin
      step_arm_q <= (state_q == S_T0) && (step_arm_q || step);
    end
  end

  assign fetch_go = step_arm_q;
`else
  assign fetch_go = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Instruction register: captured at the close of T1 and held until the
  // next T1, which keeps jmp_add stable across the whole execute phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_q <= '0;
    end else if (state_q == S_T1) begin
      ir_q <= mem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: state_nxt = S_T0;
      S_T0:   state_nxt = fetch_go ? S_T1 : S_T0;
      S_T1:   state_nxt = S_T2;
      S_T2: begin
        // Decode: the IR was loaded on the T1 edge, so op is valid here.
        if (op == OP_NOP) begin
          state_nxt = S_T0;
        end else if (op == OP_HLT) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_T3;
        end
      end
      S_T3:   state_nxt = is_mem_op ? S_T4 : S_T0;
      S_T4:   state_nxt = S_T0;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Process 3: Moore output decode (state register + IR only, except JZ which
  // qualifies jmp with zero_flag while sitting in T3)
  // ---------------------------------------------------------------------------
  always_comb begin
    mar_load = 1'b0;
    mar_sel  = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    jmp      = 1'b0;
    acc_load = 1'b0;
    acc_src  = 1'b0;
    alu_sub  = 1'b0;
    mem_we   = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_T0: begin
        // Address fetch from the PC; suppressed while a single-step stall holds.
        mar_load = fetch_go;
        mar_sel  = 1'b0;
      end
      S_T1: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      S_T3: begin
        if (is_mem_op) begin
          mar_load = 1'b1;
          mar_sel  = 1'b1;
        end else if (op == OP_JMP) begin
          jmp = 1'b1;
        end else if (op == OP_JZ) begin
          jmp = zero_flag;
        end
      end
      S_T4: begin
        case (op)
          OP_LDA: begin
            acc_load = 1'b1;
            acc_src  = 1'b0;
          end
          OP_ADD: begin
            acc_load = 1'b1;
            acc_src  = 1'b1;
            alu_sub  = 1'b0;
          end
          OP_SUB: begin
            acc_load = 1'b1;
            acc_src  = 1'b1;
            alu_sub  = 1'b1;
          end
          OP_STA: begin
            mem_we = 1'b1;
          end
          default: begin
          end
        endcase
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign jmp_add   = operand;
  assign state_dbg = state_q;

endmodule
